icache: RTL
===========

Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch stage and memory_control.
- Serves instruction fetches in zero cycles on a hit.
- On a miss, issues a single-word refill through the iREN/iaddr/iwait/iload channel. The arbiter grants that channel only when no data request is pending.
- Keeps hit and miss counters for performance reporting.

Parameters:
- SETS, 16, number of frames; power of two, at least 2; index width IDXW = log2(SETS).
- CNTW, 32, width of the hit and miss counters.

Ports:
- CLK  in  1  system clock, rising-edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  datapath requests an instruction fetch.
- imemaddr  in  32  byte address of the fetch; bits [1:0] are ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  instruction word; valid only when ihit=1.
- iREN  out  1  refill read request to memory_control.
- iaddr  out  32  refill word address, always word-aligned.
- iwait  in  1  memory_control stall; 0 means iload is valid this cycle.
- iload  in  32  refill data from memory_control.
- hitcnt  out  CNTW  number of hits since reset.
- misscnt  out  CNTW  number of misses since reset.

Behaviour:
- Address split:
  - bytoff = addr[1:0]
  - idx = addr[IDXW+1:2]
  - tag = addr[31:IDXW+2]
- Storage per frame: valid bit, tag, 32-bit data word. Registers only, no SRAM macro.
- Reset (nRST low, asynchronous):
  - all valid bits cleared, state goes to IDLE, hitcnt=0, misscnt=0
  - outputs: ihit=0, iREN=0, iaddr=0, imemload=0
  - tag and data contents are don't-care
- State IDLE:
  - Hit when imemREN=1 and valid[idx]=1 and tag matches.
    - ihit=1 combinationally in the same cycle; imemload=data[idx].
    - hitcnt increments on the clock edge.
  - Miss when imemREN=1 and the lookup fails.
    - ihit=0.
    - Latch missaddr = {imemaddr[31:2],2'b00}.
    - misscnt increments once.
    - Next state FETCH.
  - When imemREN=0: ihit=0, no state change.
  - iREN=0 throughout IDLE.
- State FETCH:
  - Drive iREN=1 and iaddr=missaddr; ihit=0.
  - No lookup is performed.
  - While iwait=1, hold. This covers both arbiter denial (data side has priority) and RAM latency; there is no timeout.
  - When iwait=0, on the clock edge:
    - frame[missaddr idx] gets valid=1, tag from missaddr, data=iload
    - next state IDLE
  - iREN drops to 0 in the cycle after the accepted word.
- Miss latency: miss detected in cycle N, iREN asserted from N+1, word accepted in cycle M (first cycle with iwait=0), ihit=1 in M+1 if the address is unchanged.
- Datapath changes imemaddr during FETCH (branch or jump):
  - The refill still completes to the latched missaddr; a RAM transaction is never aborted.
  - The new address is looked up in IDLE after the refill.
  - misscnt counts only the original miss.
- imemREN drops during FETCH: the refill still completes and installs.
- Counters wrap modulo 2^CNTW; no saturation.
- Conflicting tag on the same index: the refill overwrites unconditionally. There is no write-back because the cache is read-only.
- Reset asserted mid-FETCH: the refill is abandoned immediately and iREN=0 asynchronously. A late iwait=0 after reset is ignored.
- Never both ihit=1 and iREN=1 in the same cycle.

Decomposition:
- Add to cpu_types_pkg:
  - icachef_t: packed struct of tag, idx and bytoff
  - icache_frame_t: packed struct of valid, tag, data
  - enum icache_state_t {IDLE, FETCH}
- word_t is reused for all 32-bit buses.
- No sub-module. Frame array, FSM and counters stay in icache; the block is small enough to stay flat.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x00000040, memory returns iwait=1 for 2 cycles then iwait=0 with iload=0x8C220004.
  - Required: iREN=1 and iaddr=0x00000040 from the cycle after the request until acceptance.
  - ihit=1 and imemload=0x8C220004 one cycle later.
  - misscnt=1, hitcnt=1 after that hit.
- Hit after fill: re-fetch 0x00000040, then 0x00000042 (bytoff ignored).
  - Required: ihit=1 in the same cycle for both; iREN stays 0; hitcnt increments by 2.
- Conflict eviction with SETS=16: fill 0x00000004, then fetch 0x00000044 (same idx=1, different tag).
  - Required: miss and refill; then re-fetching 0x00000004 misses again.
  - misscnt=3 total.
- Address change mid-refill: miss on 0x00000100, switch imemaddr to 0x00000200 while iwait=1.
  - Required: iaddr stays 0x00000100 until acceptance; frame idx 0 holds tag of 0x100.
  - Next cycle 0x200 misses with iaddr=0x00000200.
- Arbiter denial: during FETCH hold iwait=1 for 10 cycles (data side busy).
  - Required: iREN held at 1, ihit=0, state unchanged, no counter change.
- Reset mid-FETCH: assert nRST=0 while iREN=1.
  - Required: iREN=0 immediately; after release a fetch of the previously filled address misses (valid bits cleared); counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word plus the instruction-cache address view, frame and FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Field widths for the default 16-frame configuration.
  localparam int unsigned ICACHE_IDXW = 4;
  localparam int unsigned ICACHE_TAGW = 32 - ICACHE_IDXW - 2;

  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, single-word refill on a miss,
// and hit/miss counters for performance reporting.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = 16,
  parameter int unsigned CNTW = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            imemREN,
  input  word_t           imemaddr,
  output logic            ihit,
  output word_t           imemload,
  output logic            iREN,
  output word_t           iaddr,
  input  logic            iwait,
  input  word_t           iload,
  output logic [CNTW-1:0] hitcnt,
  output logic [CNTW-1:0] misscnt
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 32 - IDXW - 2;

  icache_state_t   state_q, state_d;
  word_t           missaddr_q, missaddr_d;
  logic [CNTW-1:0] hitcnt_q, hitcnt_d;
  logic [CNTW-1:0] misscnt_q, misscnt_d;

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  word_t           data_q [SETS];

  logic [IDXW-1:0] lk_idx, fill_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lookup_hit, fill;
  logic            unused_bytoff;

  assign lk_idx        = imemaddr[IDXW+1:2];
  assign lk_tag        = imemaddr[31:IDXW+2];
  assign fill_idx      = missaddr_q[IDXW+1:2];
  assign unused_bytoff = ^imemaddr[1:0];

  assign lookup_hit = imemREN && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign fill       = (state_q == FETCH) && !iwait;

  always_comb begin
    state_d    = state_q;
    missaddr_d = missaddr_q;
    hitcnt_d   = hitcnt_q;
    misscnt_d  = misscnt_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    unique case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[lk_idx];
            hitcnt_d = hitcnt_q + 1'b1;
          end else begin
            missaddr_d = {imemaddr[31:2], 2'b00};
            misscnt_d  = misscnt_q + 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        // The refill always lands at the latched miss address, whatever the fetch port does.
        iREN  = 1'b1;
        iaddr = missaddr_q;
        if (!iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      missaddr_q <= '0;
      hitcnt_q   <= '0;
      misscnt_q  <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      missaddr_q <= missaddr_d;
      hitcnt_q   <= hitcnt_d;
      misscnt_q  <= misscnt_d;
      if (fill) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data need no reset: a frame is only read once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= missaddr_q[31:IDXW+2];
      data_q[fill_idx] <= iload;
    end
  end

  assign hitcnt  = hitcnt_q;
  assign misscnt = misscnt_q;

endmodule
